// File: rtl/rftfa_pkg.sv
// Shared constants and types for the round-trip fault-tolerance harness.
// Count decoder option: CNT_DEC_CHECK_EN.
package rftfa_pkg;

  localparam int W_IN      = 4;
  localparam int W_OUT     = 7;
  localparam int MAX_COUNT = 7;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  function automatic logic [W_OUT-1:0] reverse(
    input logic [W_OUT-1:0] w
  );
    logic [W_OUT-1:0] r;
    for (int i = 0; i < W_OUT; i++) begin
      r[i] = w[W_OUT-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/count_decoder_if.sv
// Count-in / word-out handshake bundle for count_decoder.
// mismatch is meaningful only with CNT_DEC_CHECK_EN.
interface count_decoder_if;
  import rftfa_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [W_IN-1:0]  in_count;
  logic             out_valid;
  logic             out_ready;
  logic [W_OUT-1:0] out;
  logic             err;
  logic             mismatch;

  modport master (
    output in_valid,
    output in_count,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out,
    input  err,
    input  mismatch
  );

  modport slave (
    input  in_valid,
    input  in_count,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out,
    output err,
    output mismatch
  );

endinterface

// File: rtl/count_decoder_popcount7.sv
// Combinational ones counter over a 7-bit word.
// Used by count_decoder under CNT_DEC_CHECK_EN.
module popcount7 (
  input  logic [6:0] word,
  output logic [2:0] ones
);

  always_comb begin
    ones = '0;
    for (int i = 0; i < 7; i++) begin
      ones = ones + 3'(word[i]);
    end
  end

endmodule

// File: rtl/count_decoder.sv
// Bit-serial ones-count to thermometer decoder.
// Optional popcount self-check: define CNT_DEC_CHECK_EN.
module count_decoder
  import rftfa_pkg::*;
#(
  parameter int W_IN  = rftfa_pkg::W_IN,
  parameter int W_OUT = rftfa_pkg::W_OUT
) (
  input logic            clk,
  input logic            rst_n,
  count_decoder_if.slave bus
);

  localparam int BW = $clog2(W_OUT);

  logic [1:0]       rsync;
  logic             rst_q;
  state_t           state;
  state_t           nxt;
  logic [W_IN-1:0]  rem;
  logic [W_IN-1:0]  sat;
  logic [BW-1:0]    bitcnt;
  logic [W_OUT-1:0] shreg;
  logic [W_OUT-1:0] word;
  logic [W_OUT-1:0] outr;
  logic             over;
  logic             bitin;
  logic             errl;
  logic             errq;
  logic             accept;
  logic             last;
  logic             done;

  // async assert, release after two clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsync <= '0;
    else        rsync <= {rsync[0], 1'b1};
  end

  assign rst_q = rsync[1];

  assign over   = bus.in_count > W_IN'(MAX_COUNT);
  assign sat    = over ? W_IN'(MAX_COUNT) : bus.in_count;
  assign bitin  = rem != '0;
  assign word   = {shreg[W_OUT-2:0], bitin};
  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (state == SHIFT) && (bitcnt == BW'(W_OUT-1));
  assign done   = (state == HOLD) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_q) begin
    if (!rst_q) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt           = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (1'b1)
      state == IDLE:  begin
        bus.in_ready = 1'b1;
        if (accept) nxt = SHIFT;
      end
      state == SHIFT: begin
        if (last) nxt = HOLD;
      end
      state == HOLD:  begin
        bus.out_valid = 1'b1;
        if (done) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_q) begin
    if (!rst_q) begin
      rem    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      outr   <= '0;
      errl   <= 1'b0;
      errq   <= 1'b0;
    end else if (accept) begin
      rem    <= sat;
      errl   <= over;
      bitcnt <= '0;
      shreg  <= '0;
    end else if (state == SHIFT) begin
      shreg  <= word;
      rem    <= rem - W_IN'(bitin);
      bitcnt <= bitcnt + 1'b1;
      // first bit in ends up at the MSB, so flip it into out[0]
      if (last) begin
        outr <= reverse(word);
        errq <= errl;
      end
    end
  end

  assign bus.out = outr;
  assign bus.err = errq;

`ifdef CNT_DEC_CHECK_EN
  logic [W_IN-1:0] cnt;
  logic [2:0]      ones;
  logic            mis;

  popcount7 u_pc (
    .word (word),
    .ones (ones)
  );

  always_ff @(posedge clk or negedge rst_q) begin
    if (!rst_q) begin
      cnt <= '0;
      mis <= 1'b0;
    end else begin
      if (accept) cnt <= sat;
      if (last)      mis <= W_IN'(ones) != cnt;
      else if (done) mis <= 1'b0;
    end
  end

  assign bus.mismatch = mis;
`else
  assign bus.mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_count_decoder.sv
// Directed self-checking bench for count_decoder.
// Checker scenario runs only with CNT_DEC_CHECK_EN.
module tb_count_decoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   lat;

  count_decoder_if bus ();

  count_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int l);
    l = 1;
    while (!bus.out_valid && l < 30) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic send(input logic [3:0] c, output int l);
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_count = c;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(l);
  endtask

  task automatic finish_hold();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("valid_drop", 32'(bus.out_valid), 0);
    chk("ready_back", 32'(bus.in_ready), 1);
    chk("mis_clear", 32'(bus.mismatch), 0);
  endtask

  task automatic run(
    input logic [3:0] c,
    input logic [6:0] eo,
    input logic       ee
  );
    int l;
    send(c, l);
    chk("latency", 32'(l), 8);
    chk("out", 32'(bus.out), 32'(eo));
    chk("err", 32'(bus.err), 32'(ee));
    chk("mismatch", 32'(bus.mismatch), 0);
    chk("in_ready_hold", 32'(bus.in_ready), 0);
    finish_hold();
  endtask

  initial begin
    logic [6:0] e;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_count  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out", 32'(bus.out), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_mismatch", 32'(bus.mismatch), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run(4'd3, 7'b0000111, 1'b0);
    run(4'd3, 7'b0000111, 1'b0);
    run(4'd4, 7'b0001111, 1'b0);
    run(4'd0, 7'b0000000, 1'b0);
    run(4'd7, 7'b1111111, 1'b0);
    run(4'd9, 7'b1111111, 1'b1);
    run(4'd15, 7'b1111111, 1'b1);
    run(4'd2, 7'b0000011, 1'b0);

    for (int c = 0; c < 16; c++) begin
      e = (c > 7) ? 7'h7f : 7'((1 << c) - 1);
      run(4'(c), e, c > 7);
    end

    send(4'd6, lat);
    chk("bp_latency", 32'(lat), 8);
    bus.in_valid = 1'b1;
    bus.in_count = 4'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_out", 32'(bus.out), 32'h3f);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_ready_after", 32'(bus.in_ready), 1);
    chk("bp_valid_after", 32'(bus.out_valid), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_accepted", 32'(bus.in_ready), 0);
    wait_valid(lat);
    chk("bp2_latency", 32'(lat), 8);
    chk("bp2_out", 32'(bus.out), 32'h01);
    finish_hold();

    run(4'd12, 7'b1111111, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_count = 4'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_in_ready", 32'(bus.in_ready), 1);
    chk("mid_out_valid", 32'(bus.out_valid), 0);
    chk("mid_out", 32'(bus.out), 0);
    chk("mid_err", 32'(bus.err), 0);
    chk("mid_mismatch", 32'(bus.mismatch), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run(4'd1, 7'b0000001, 1'b0);

`ifdef CNT_DEC_CHECK_EN
    force dut.shreg[2] = 1'b0;
    send(4'd5, lat);
    chk("chk_latency", 32'(lat), 8);
    chk("chk_mismatch", 32'(bus.mismatch), 1);
    @(negedge clk);
    chk("chk_mis_hold", 32'(bus.mismatch), 1);
    release dut.shreg[2];
    finish_hold();
    run(4'd5, 7'b0011111, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
